// File: rtl/bsg_xnor_compare_arb.sv
// Round-robin arbitrated XNOR comparator shared by els_p requesters, feeding
// a one-entry result register drained through a valid/yumi handshake.
module bsg_xnor_compare_arb #(
    parameter int unsigned width_p = 16,
    parameter int unsigned els_p   = 4,
    localparam int unsigned id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned cnt_width_lp = $clog2(width_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [els_p-1:0]            v_i,
    input  logic [els_p*width_p-1:0]    a_i,
    input  logic [els_p*width_p-1:0]    b_i,
    output logic [els_p-1:0]            yumi_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic                        match_o,
    output logic [cnt_width_lp-1:0]     count_o,
    output logic [id_width_lp-1:0]      id_o,
    input  logic                        yumi_i
);

    logic                    v_q, v_d;
    logic [width_p-1:0]      data_q, data_d;
    logic                    match_q, match_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [id_width_lp-1:0]  id_q, id_d;
    logic [id_width_lp-1:0]  last_q, last_d;

    logic                    free_c;
    logic                    gnt_v_c;
    logic [id_width_lp-1:0]  gnt_id_c;
    logic [id_width_lp-1:0]  cand_c;
    logic [width_p-1:0]      xnor_c;
    logic [cnt_width_lp-1:0] cnt_c;

    // Slot is free when empty or being drained this cycle.
    assign free_c = ~v_q | yumi_i;

    // Scan upward from the requester after the last grant; first hit wins.
    always_comb begin
        gnt_v_c  = 1'b0;
        gnt_id_c = '0;
        cand_c   = '0;
        yumi_o   = '0;
        if (!reset_i && free_c) begin
            for (int unsigned s = 1; s <= els_p; s++) begin
                cand_c = id_width_lp'((32'(last_q) + s) % els_p);
                if (!gnt_v_c && v_i[cand_c]) begin
                    gnt_v_c         = 1'b1;
                    gnt_id_c        = cand_c;
                    yumi_o[cand_c]  = 1'b1;
                end
            end
        end
    end

    // Shared compare datapath on the granted operand pair.
    always_comb begin
        xnor_c = ~(a_i[32'(gnt_id_c)*width_p +: width_p] ^ b_i[32'(gnt_id_c)*width_p +: width_p]);
        cnt_c  = '0;
        for (int unsigned i = 0; i < width_p; i++) begin
            cnt_c = cnt_c + cnt_width_lp'(xnor_c[i]);
        end
    end

    // Load on grant (also covers drain+load in one edge); drain clears valid only.
    always_comb begin
        v_d     = v_q;
        data_d  = data_q;
        match_d = match_q;
        count_d = count_q;
        id_d    = id_q;
        last_d  = last_q;
        if (gnt_v_c) begin
            v_d     = 1'b1;
            data_d  = xnor_c;
            match_d = &xnor_c;
            count_d = cnt_c;
            id_d    = gnt_id_c;
            last_d  = gnt_id_c;
        end else if (yumi_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q     <= 1'b0;
            data_q  <= '0;
            match_q <= 1'b0;
            count_q <= '0;
            id_q    <= '0;
            last_q  <= id_width_lp'(els_p - 1);
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            match_q <= match_d;
            count_q <= count_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign v_o     = v_q;
    assign data_o  = data_q;
    assign match_o = match_q;
    assign count_o = count_q;
    assign id_o    = id_q;

endmodule

// File: tb/tb_bsg_xnor_compare_arb.sv
// Scoreboard bench for bsg_xnor_compare_arb: directed scenarios followed by
// randomized requests, backpressure and resets checked against a queue model.
module tb_bsg_xnor_compare_arb;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;
    localparam int CW  = 5;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [N-1:0]     v_i;
    logic [N*W-1:0]   a_i, b_i;
    logic [N-1:0]     yumi_o;
    logic             v_o;
    logic [W-1:0]     data_o;
    logic             match_o;
    logic [CW-1:0]    count_o;
    logic [IDW-1:0]   id_o;
    logic             yumi_i;

    bsg_xnor_compare_arb #(.width_p(W), .els_p(N)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .a_i(a_i), .b_i(b_i),
        .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .match_o(match_o),
        .count_o(count_o), .id_o(id_o), .yumi_i(yumi_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   d;
        logic           m;
        logic [CW-1:0]  c;
        logic [IDW-1:0] id;
    } res_t;

    // Requester-side state and reference model.
    bit          pend [N];
    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    int          mdl_last;
    bit          mdl_vo;
    res_t        exp_q[$];
    res_t        held;
    int          gnt_log[$];
    int          checks = 0;
    int          errors = 0;
    int          ymode;
    bit          auto_req, refill, mon_en;
    int          exp_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[k] = 1'b1;
        ra[k]   = a;
        rb[k]   = b;
    endtask

    function automatic res_t expect_res(input int k);
        res_t r;
        r.d  = ~(ra[k] ^ rb[k]);
        r.m  = (ra[k] == rb[k]);
        r.c  = CW'($countones(r.d));
        r.id = IDW'(k);
        return r;
    endfunction

    // Round-robin rule: first pending requester after the last grant, if the slot is free.
    function automatic int model_grant();
        if (reset_i || !(!mdl_vo || yumi_i)) return -1;
        for (int s = 1; s <= N; s++) begin
            if (pend[(mdl_last + s) % N]) return (mdl_last + s) % N;
        end
        return -1;
    endfunction

    task automatic new_ops(input int k);
        logic [W-1:0] a;
        a = W'($urandom);
        case ($urandom_range(0, 3))
            0:       req(k, a, a);
            1:       req(k, a, a ^ (W'(1) << $urandom_range(0, W-1)));
            default: req(k, a, W'($urandom));
        endcase
    endtask

    // One clock: drive after posedge, check grant at negedge, advance model at posedge.
    task automatic cycle();
        logic [N-1:0]   vv;
        logic [N*W-1:0] av, bv;
        logic [N-1:0]   exp_y;
        for (int k = 0; k < N; k++) begin
            if (!pend[k] && (refill || (auto_req && $urandom_range(0, 2) == 0))) new_ops(k);
            vv[k]          = pend[k];
            av[k*W +: W]   = ra[k];
            bv[k*W +: W]   = rb[k];
        end
        v_i = vv;
        a_i = av;
        b_i = bv;
        case (ymode)
            0:       yumi_i = mdl_vo & !reset_i;
            1:       yumi_i = 1'b0;
            default: yumi_i = mdl_vo & !reset_i & ($urandom_range(0, 1) == 1);
        endcase
        exp_gnt = model_grant();
        @(negedge clk);
        exp_y = '0;
        if (exp_gnt >= 0) exp_y[exp_gnt] = 1'b1;
        chk("yumi_o", 32'(yumi_o), 32'(exp_y));
        chk("yumi_o_onehot0", 32'($onehot0(yumi_o)), 32'd1);
        chk("yumi_o_implies_v_i", 32'(yumi_o & ~v_i), 32'd0);
        for (int k = 0; k < N; k++) if (yumi_o[k]) gnt_log.push_back(k);
        @(posedge clk);
        if (reset_i) begin
            mdl_vo   = 1'b0;
            mdl_last = N - 1;
            exp_q.delete();
            held     = '0;
        end else if (exp_gnt >= 0) begin
            exp_q.push_back(expect_res(exp_gnt));
            mdl_vo         = 1'b1;
            mdl_last       = exp_gnt;
            pend[exp_gnt]  = 1'b0;
        end else if (yumi_i) begin
            mdl_vo = 1'b0;
        end
        #1;
    endtask

    // Monitor: compares the presented result against the scoreboard, pops on accept.
    always @(negedge clk) begin
        res_t got;
        if (mon_en) begin
            got = {data_o, match_o, count_o, id_o};
            chk("v_o", 32'(v_o), 32'(mdl_vo));
            chk("yumi_i_legal", 32'(yumi_i & ~v_o), 32'd0);
            if (mdl_vo) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got result %0h with nothing expected", got);
                end else begin
                    chk("result_d", 32'(got.d), 32'(exp_q[0].d));
                    chk("result_mci", {23'd0, got.m, got.c, got.id}, {23'd0, exp_q[0].m, exp_q[0].c, exp_q[0].id});
                    if (yumi_i) held = exp_q.pop_front();
                end
            end else begin
                chk("held_result", {got.d, 7'd0, got.m, got.c, got.id}, {held.d, 7'd0, held.m, held.c, held.id});
            end
        end
    end

    initial begin
        logic [W-1:0] saved;
        int           exp_rr [6] = '{0, 1, 2, 3, 0, 1};
        mon_en   = 1'b0;
        auto_req = 1'b0;
        refill   = 1'b0;
        ymode    = 0;
        mdl_vo   = 1'b0;
        mdl_last = N - 1;
        held     = '0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            ra[k]   = '0;
            rb[k]   = '0;
        end
        v_i     = '0;
        a_i     = '0;
        b_i     = '0;
        yumi_i  = 1'b0;
        reset_i = 1'b1;
        cycle();
        cycle();
        reset_i = 1'b0;
        mon_en  = 1'b1;
        chk("reset_v_o", 32'(v_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'd0);
        chk("reset_count_id", {30'd0, count_o == 0, id_o == 0}, 32'd3);

        // Single matching request.
        req(0, 16'hA5A5, 16'hA5A5);
        cycle();
        chk("tp1_data", 32'(data_o), 32'h0000FFFF);
        chk("tp1_match", 32'(match_o), 32'd1);
        chk("tp1_count", 32'(count_o), 32'd16);
        chk("tp1_id", 32'(id_o), 32'd0);
        cycle();

        // Mismatch arithmetic.
        req(2, 16'h00FF, 16'h0F0F);
        cycle();
        chk("tp2_data", 32'(data_o), 32'h0000F00F);
        chk("tp2_match", 32'(match_o), 32'd0);
        chk("tp2_count", 32'(count_o), 32'd8);
        chk("tp2_id", 32'(id_o), 32'd2);
        cycle();
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;

        // Round-robin with all requesters held high and full drain.
        refill = 1'b1;
        gnt_log.delete();
        for (int i = 0; i < 6; i++) cycle();
        chk("rr_len", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("rr_order", 32'(gnt_log[i]), 32'(exp_rr[i]));
        chk("rr_last_id", 32'(id_o), 32'd1);

        // Backpressure for three cycles, then release.
        ymode = 1;
        gnt_log.delete();
        saved = data_o;
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_no_grant", 32'(gnt_log.size()), 32'd0);
        chk("bp_data_stable", 32'(data_o), 32'(saved));
        ymode = 0;
        cycle();
        chk("bp_release_len", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() > 0) chk("bp_release_gnt", 32'(gnt_log[0]), 32'd2);

        // Let the rest drain, then drain+load vs drain only.
        refill = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        req(3, 16'h1234, 16'h1234);
        cycle();
        chk("dl_v_o", 32'(v_o), 32'd1);
        chk("dl_id", 32'(id_o), 32'd3);
        saved = data_o;
        cycle();
        chk("drain_v_o", 32'(v_o), 32'd0);
        chk("drain_data_hold", 32'(data_o), 32'(saved));

        // Reset mid-operation with a buffered result.
        req(1, 16'hBEEF, 16'hBEEF);
        cycle();
        chk("mid_id", 32'(id_o), 32'd1);
        ymode = 1;
        req(1, 16'h0001, 16'h0003);
        req(2, 16'h0F00, 16'h0F00);
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        chk("mid_reset_v_o", 32'(v_o), 32'd0);
        ymode = 0;
        gnt_log.delete();
        cycle();
        chk("mid_first_len", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() > 0) chk("mid_first_gnt", 32'(gnt_log[0]), 32'd1);

        // Randomized traffic with random backpressure and occasional resets.
        auto_req = 1'b1;
        ymode    = 2;
        for (int i = 0; i < 3000; i++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset_i = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
